// File: rtl/conv_stream_engine.sv
// Streaming multi-filter 1-D convolution engine: F parallel K-tap filters over a
// framed sample stream, with a registered valid/ready output stage and optional ReLU.
module conv_stream_engine #(
  parameter int DW = 8,
  parameter int K  = 4,
  parameter int F  = 2,
  parameter int LW = 8,
  localparam int KW = (K > 1) ? $clog2(K) : 1,
  localparam int FW = (F > 1) ? $clog2(F) : 1,
  localparam int OW = 2 * DW + $clog2(K)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LW-1:0]        len,
  input  logic                 relu,
  input  logic                 coef_we,
  input  logic [FW-1:0]        coef_f,
  input  logic [KW-1:0]        coef_k,
  input  logic [DW-1:0]        coef_d,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [F*OW-1:0]      out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = 2 * DW;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [LW-1:0] KM1  = LW'(K - 1);
  localparam logic [LW-1:0] KLEN = LW'(K);

  logic [1:0]            state_r;
  logic [LW-1:0]         cnt_r;
  logic [LW-1:0]         len_r;
  logic                  relu_r;
  logic signed [DW-1:0]  win_r  [K];
  logic signed [DW-1:0]  win_s  [K];
  logic signed [DW-1:0]  coef_r [F][K];
  logic                  out_valid_r;
  logic [F*OW-1:0]       out_data_r;
  logic [F*OW-1:0]       y_s;
  logic                  in_ready_s;
  logic                  acc_s;
  logic                  load_s;
  logic                  fin_s;
  logic                  start_ok_s;

  // handshake and frame-control decode
  always_comb begin
    in_ready_s = (state_r == RUN) && (cnt_r < len_r) && !(out_valid_r && !out_ready);
    acc_s      = in_valid && in_ready_s;
    load_s     = acc_s && (cnt_r >= KM1);
    // the frame ends once every sample is in and the last result is handed off
    fin_s      = (state_r == RUN) && (cnt_r == len_r) && (!out_valid_r || out_ready);
    start_ok_s = (state_r == IDLE) && start;
  end

  // window as it will look after the current sample shifts in
  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      win_s[j] = win_r[j + 1];
    end
    win_s[K-1] = in_data;
  end

  // per-filter dot product at full precision, then optional ReLU clamp
  always_comb begin
    logic signed [PW-1:0] prod_v;
    logic [OW-1:0]        sum_v;
    y_s    = '0;
    prod_v = '0;
    sum_v  = '0;
    for (int f = 0; f < F; f++) begin
      sum_v = '0;
      for (int j = 0; j < K; j++) begin
        prod_v = PW'(coef_r[f][j]) * PW'(win_s[j]);
        sum_v  = sum_v + {{(OW - PW){prod_v[PW-1]}}, prod_v};
      end
      if (relu_r && sum_v[OW-1]) begin
        y_s[f*OW +: OW] = '0;
      end else begin
        y_s[f*OW +: OW] = sum_v;
      end
    end
  end

  // frame FSM, sample counter and latched frame settings
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      len_r   <= '0;
      relu_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            cnt_r  <= '0;
            len_r  <= len;
            relu_r <= relu;
            state_r <= (len >= KLEN) ? RUN : DONE;
          end
        end
        RUN: begin
          if (acc_s) begin
            cnt_r <= cnt_r + 1'b1;
          end
          if (fin_s) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // sample window: cleared at frame start, shifts on every accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < K; j++) begin
        win_r[j] <= '0;
      end
    end else if (start_ok_s) begin
      for (int j = 0; j < K; j++) begin
        win_r[j] <= '0;
      end
    end else if (acc_s) begin
      for (int j = 0; j < K; j++) begin
        win_r[j] <= win_s[j];
      end
    end
  end

  // coefficient bank, writable only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < F; f++) begin
        for (int j = 0; j < K; j++) begin
          coef_r[f][j] <= '0;
        end
      end
    end else if (coef_we && (state_r == IDLE) && (int'(coef_f) < F) && (int'(coef_k) < K)) begin
      coef_r[coef_f][coef_k] <= coef_d;
    end
  end

  // output register: a new result may replace one being consumed on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= y_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign done      = (state_r == DONE);

endmodule

// File: tb/tb_conv_stream_engine.sv
// Randomized self-checking bench for conv_stream_engine: a frame-level reference
// model computes expected results straight from the convolution definition.
module tb_conv_stream_engine;

  localparam int DW = 8;
  localparam int K  = 4;
  localparam int F  = 2;
  localparam int LW = 8;
  localparam int OW = 2 * DW + $clog2(K);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LW-1:0]     len = '0;
  logic              relu = 1'b0;
  logic              coef_we = 1'b0;
  logic [0:0]        coef_f = '0;
  logic [1:0]        coef_k = '0;
  logic [DW-1:0]     coef_d = '0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [F*OW-1:0]   out_data;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;

  int n_chk  = 0;
  int n_fail = 0;
  int cm [F][K];

  conv_stream_engine #(.DW(DW), .K(K), .F(F), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .relu(relu),
    .coef_we(coef_we), .coef_f(coef_f), .coef_k(coef_k), .coef_d(coef_d),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_coef(input int f, input int k, input int d);
    @(negedge clk);
    coef_we = 1'b1;
    coef_f  = f[0:0];
    coef_k  = k[1:0];
    coef_d  = DW'(d);
    @(negedge clk);
    coef_we = 1'b0;
    cm[f][k] = d;
  endtask

  task automatic load_directed();
    int c0 [K] = '{1, 1, 1, 1};
    int c1 [K] = '{1, -1, 0, 0};
    for (int j = 0; j < K; j++) begin
      wr_coef(0, j, c0[j]);
      wr_coef(1, j, c1[j]);
    end
  endtask

  // mode 0: random traffic, 1: mid-frame start + coef write, 2: 3-cycle stall on first output
  task automatic run_frame(input int flen, input bit frelu, input int pv, input int pr,
                           input int mode, input bit seq);
    int     samp[$];
    longint expq[$];
    int     idx = 0, nout = 0, ndone = 0, stall = 0, c = 0, last_out = -10, done_c = -1;
    bit     first_seen = 0, prev_stall = 0, hold_v = 0, acc;
    logic [F*OW-1:0] prev_data = '0;
    longint y;

    for (int i = 0; i < flen; i++) begin
      samp.push_back(seq ? (i + 1) : (int'($urandom_range(255)) - 128));
    end
    for (int n = K - 1; n < flen; n++) begin
      for (int f = 0; f < F; f++) begin
        y = 0;
        for (int j = 0; j < K; j++) begin
          y += longint'(cm[f][j]) * longint'(samp[n - K + 1 + j]);
        end
        if (frelu && y < 0) y = 0;
        expq.push_back(y);
      end
    end

    @(negedge clk);
    start = 1'b1;
    len   = LW'(flen);
    relu  = frelu;
    @(negedge clk);
    start = 1'b0;

    while (ndone == 0 && c < 4000) begin
      out_ready = (stall > 0) ? 1'b0 : (int'($urandom_range(99)) < pr);
      if (!hold_v) in_valid = (int'($urandom_range(99)) < pv);
      in_data = (idx < flen) ? DW'(samp[idx]) : DW'($urandom);
      if (mode == 1 && c == 3) begin
        start = 1'b1; len = LW'(2); coef_we = 1'b1; coef_f = 1'b0; coef_k = 2'd0; coef_d = 8'd55;
      end else begin
        start = 1'b0; coef_we = 1'b0;
      end
      #1;
      if (mode == 2 && out_valid && !first_seen) begin
        first_seen = 1;
        stall = 3;
        out_ready = 1'b0;
        #1;
      end
      if (done) begin
        ndone++;
        done_c = c;
      end
      if (out_valid && prev_stall) check("hold_data", longint'(out_data), longint'(prev_data));
      if (stall > 0) check("stall_in_ready", longint'(in_ready), 0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        for (int f = 0; f < F; f++) begin
          if (expq.size() > 0) begin
            check($sformatf("out%0d_f%0d", nout, f),
                  longint'($signed(out_data[f*OW +: OW])), expq.pop_front());
          end else begin
            check("extra_output", 1, 0);
          end
        end
        nout++;
        last_out = c;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      hold_v     = in_valid && !acc && (idx < flen);
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      c++;
      if (stall > 0) stall--;
    end

    in_valid  = 1'b0;
    start     = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b0;
    #1;
    check("frame_timeout", longint'(c < 4000), 1);
    check("n_outputs", nout, (flen >= K) ? (flen - K + 1) : 0);
    check("n_consumed", idx, (flen >= K) ? flen : 0);
    check("exp_left", expq.size(), 0);
    if (flen >= K) check("done_after_last", done_c, last_out + 1);
    else           check("short_done_lat", done_c, 0);
    check("busy_after", longint'(busy), 0);
    check("done_pulse", longint'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (done || out_valid) check("spurious_after_frame", 1, 0);
    end
  endtask

  task automatic reset_mid_frame();
    int n = 0;
    int guard = 0;
    @(negedge clk);
    start = 1'b1; len = LW'(5); relu = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (n < 2 && guard < 50) begin
      in_data = DW'(n + 1);
      #1;
      if (in_valid && in_ready) n++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("rst_pre_busy", longint'(busy), 1);
    check("rst_pre_guard", longint'(guard < 50), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_data", longint'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < F; f++)
      for (int j = 0; j < K; j++)
        cm[f][j] = 0;
  endtask

  initial begin
    for (int f = 0; f < F; f++)
      for (int j = 0; j < K; j++)
        cm[f][j] = 0;
    #1;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_in_ready", longint'(in_ready), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load_directed();
    run_frame(5, 1'b0, 100, 100, 0, 1'b1);
    run_frame(5, 1'b1, 100, 100, 0, 1'b1);
    run_frame(5, 1'b0, 100, 100, 2, 1'b1);
    run_frame(3, 1'b0, 100, 100, 0, 1'b1);
    run_frame(8, 1'b0, 100, 100, 1, 1'b0);
    run_frame(4, 1'b0, 60, 60, 0, 1'b0);

    reset_mid_frame();
    run_frame(5, 1'b0, 100, 100, 0, 1'b0);
    load_directed();
    run_frame(5, 1'b0, 100, 100, 0, 1'b1);

    for (int it = 0; it < 16; it++) begin
      for (int f = 0; f < F; f++)
        for (int j = 0; j < K; j++)
          wr_coef(f, j, int'($urandom_range(255)) - 128);
      run_frame(int'($urandom_range(12)), 1'($urandom_range(1)),
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stream_engine.md
CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

Interface
REQ-001 Parameter DW, default 8: signed sample and coefficient width.
REQ-002 Parameter K, default 4: kernel taps, K >= 2.
REQ-003 Parameter F, default 2: number of parallel filters (output channels).
REQ-004 Parameter LW, default 8: frame-length counter width.
REQ-005 Derived OW = 2*DW + clog2(K): signed result width per filter; no saturation or truncation.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle frame start; honoured only in IDLE.
REQ-009 len  in  LW  frame sample count; sampled when start is honoured.
REQ-010 relu  in  1  1 = clamp negative results to 0; sampled when start is honoured.
REQ-011 coef_we, coef_f[clog2(F)], coef_k[clog2(K)], coef_d[DW]  in: coefficient write port.
REQ-012 in_valid  in  1,  in_data  in  DW,  in_ready  out  1: input stream handshake.
REQ-013 out_valid  out  1,  out_data  out  F*OW (filter f at bits [f*OW +: OW]),  out_ready  in  1: output stream handshake.
REQ-014 busy  out  1  high in RUN and DONE; done  out  1  one-cycle end-of-frame pulse.

Function
REQ-015 Coefficient bank: F x K signed DW registers; a write occurs when coef_we=1 and state is IDLE, otherwise it is ignored; bank contents persist across frames.
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start when len >= K; IDLE->DONE on start when len < K; RUN->DONE when all len samples are accepted and no output is pending; DONE->IDLE unconditionally after one cycle.
REQ-017 done = 1 exactly in DONE; a frame with len < K produces zero outputs, and done follows start by exactly 1 cycle.
REQ-018 On entry to RUN: K-deep window cleared, sample counter cleared, len and relu latched.
REQ-019 in_ready = (state==RUN) && (accepted < len) && !(out_valid && !out_ready).
REQ-020 A sample is accepted on in_valid && in_ready; it shifts into the window so that w[K-1] is the newest sample and w[0] the oldest.
REQ-021 Once K or more samples have been accepted, each accepted sample produces one result: y_f = sum over j of c[f][j]*w[j] (with w after the shift), signed, full OW width; if relu=1 and y_f<0, then y_f=0.
REQ-022 Latency: out_valid rises the cycle after the accepting edge of the producing sample; out_data is held stable while out_valid=1 && out_ready=0.
REQ-023 The output register clears out_valid on out_valid && out_ready unless a new result loads on the same edge, in which case the new result replaces it and out_valid stays 1.
REQ-024 Each frame emits exactly len-K+1 outputs, in order, with no duplicates or drops under any in_valid or out_ready pattern.
REQ-025 Samples with in_valid while in_ready=0 are not consumed; the producer holds them.
REQ-026 start is ignored while busy=1; a coefficient write in RUN or DONE leaves the bank unchanged.
REQ-027 len is at most 2^LW-1; the accepted-sample counter does not wrap within a frame.

Reset
REQ-028 On rst=1, immediately and regardless of clk: state=IDLE, out_valid=0, out_data=0, in_ready=0, busy=0, done=0, window and counters cleared, coefficients cleared to 0.
REQ-029 Reset asserted mid-frame abandons the frame with no further outputs; after release the block is in IDLE and accepts start on the next cycle.

Verification
REQ-030 F=2, K=4; c0={1,1,1,1}, c1={1,-1,0,0}; len=5, relu=0; stream 1,2,3,4,5 with out_ready=1 -> outputs (f0,f1) = (10,-1), (14,-1); done 1 cycle after the last output; busy returns to 0.
REQ-031 Same stimulus with relu=1 -> outputs (10,0), (14,0).
REQ-032 Same stimulus with out_ready low for 3 cycles after the first out_valid -> in_ready=0 and out_data held at (10,-1) during the stall; then (14,-1) follows; exactly 2 outputs total.
REQ-033 len=3 with start -> no out_valid, done=1 on the next cycle, no samples consumed.
REQ-034 rst pulse after 2 samples of a len=5 frame -> out_valid=0 and busy=0 at once, no outputs; coefficients read back as 0 (all later results 0); a fresh frame runs normally.
REQ-035 Coefficient write during RUN, plus a start pulse mid-frame -> both ignored; results match the pre-frame coefficients; the frame completes once.
